// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte queue between a UART receiver
// and its consumer. Bytes arriving while the queue is full are dropped and
// the drop is remembered in a sticky overrun flag until software clears it.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;

    logic          pop;
    logic          wr_en;
    logic          drop;

    // Status flags are decoded from the occupancy counter so they can never
    // disagree with it; the head byte is read straight from the array.
    always_comb begin
        out_valid   = (count_q != '0);
        full        = (count_q == CW'(DEPTH));
        almost_full = (count_q >= CW'(AF_LEVEL));
        count       = count_q;
        overrun     = overrun_q;
        out_data    = mem[rd_ptr_q];
    end

    // Next-state logic: a push into a full queue only succeeds when a pop
    // frees the slot in the same cycle; otherwise the byte is dropped.
    always_comb begin
        pop       = out_valid & out_ready;
        wr_en     = in_valid & (~full | pop);
        drop      = in_valid & full & ~pop;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CW'(1);
        end
        // A new drop wins over a simultaneous clear so no loss goes unseen.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Byte storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       almost_full;
    logic       overrun;
    logic       overrun_clr;

    uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] sb [$];
    int         mcnt   = 0;
    logic       movr   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags();
        chk("count", 32'(count), 32'(mcnt));
        chk("out_valid", 32'(out_valid), 32'(mcnt > 0));
        chk("full", 32'(full), 32'(mcnt == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(mcnt >= AF));
        chk("overrun", 32'(overrun), 32'(movr));
    endtask

    // One clock cycle of stimulus; head byte compared against the scoreboard
    // before the edge, status compared after it.
    task automatic do_cycle(input logic iv, input logic [7:0] d, input logic rdy, input logic clr);
        logic       pop_e;
        logic       acc;
        logic [7:0] tmp;
        if (mcnt > 0) chk("head", 32'(out_data), 32'(sb[0]));
        pop_e       = (mcnt > 0) && rdy;
        acc         = iv && ((mcnt < DEPTH) || pop_e);
        in_valid    = iv;
        in_data     = d;
        out_ready   = rdy;
        overrun_clr = clr;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        if (pop_e) tmp = sb.pop_front();
        if (acc) sb.push_back(d);
        if (iv && !acc) movr = 1'b1;
        else if (clr) movr = 1'b0;
        mcnt = sb.size();
        chk_flags();
    endtask

    task automatic do_reset(input logic iv, input logic [7:0] d);
        reset       = 1'b1;
        in_valid    = iv;
        in_data     = d;
        out_ready   = iv;
        overrun_clr = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        mcnt = 0;
        movr = 1'b0;
        chk_flags();
    endtask

    initial begin
        reset = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        out_ready = 1'b0; overrun_clr = 1'b0;
        @(posedge clk); #1;
        do_reset(1'b0, 8'h00);

        // Pop on empty queue: ignored
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Three bytes held, then drained in order
        do_cycle(1'b1, 8'h41, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h42, 1'b0, 1'b0);
        do_cycle(1'b1, 8'h43, 1'b0, 1'b0);
        chk("cnt3", 32'(count), 32'd3);
        chk("head41", 32'(out_data), 32'h41);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_after_drain", 32'(out_valid), 32'd0);

        // Fill to full, drop one, drain
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("full16", 32'(full), 32'd1);
        do_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovr_drop", 32'(overrun), 32'd1);
        chk("cnt_after_drop", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        do_cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_pushpop_cnt", 32'(count), 32'd16);
        chk("full_pushpop_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 15; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("aa_last", 32'(out_data), 32'hAA);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Set wins over clear
        for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        do_cycle(1'b1, 8'hE1, 1'b0, 1'b0);
        do_cycle(1'b1, 8'hE2, 1'b0, 1'b1);
        chk("set_wins", 32'(overrun), 32'd1);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_alone", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming 40 bytes, pointers wrap
        for (int i = 0; i < 40; i++) begin
            do_cycle(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
            chk("stream_cnt_le1", 32'(count <= 5'd1), 32'd1);
        end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-operation with a coincident push
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        do_reset(1'b1, 8'h77);
        do_cycle(1'b1, 8'h55, 1'b0, 1'b0);
        chk("post_reset_data", 32'(out_data), 32'h55);
        chk("post_reset_cnt", 32'(count), 32'd1);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
